// File: rtl/bsg_link_pkg.sv
// Shared types and helpers for the credit-based link serializer.
package bsg_link_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } link_state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/bsg_link_credit_counter.sv
// Saturating credit up/down counter with a sticky overflow flag.
module bsg_link_credit_counter #(
  parameter int unsigned lg_max_p = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [lg_max_p:0] inc_i,
  input  logic              dec_i,
  output logic [lg_max_p:0] count_o,
  output logic              overflow_o
);

  localparam int unsigned CountW = lg_max_p + 1;
  // One extra bit so count + inc (each at most 2^lg_max_p) cannot wrap.
  localparam int unsigned SumW = lg_max_p + 2;
  localparam logic [SumW-1:0] MaxCount = SumW'(1) << lg_max_p;

  logic [CountW-1:0] count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [SumW-1:0]   sum;
  logic              over;

  always_comb begin
    sum        = {1'b0, count_q} + {1'b0, inc_i} - SumW'(dec_i);
    over       = sum > MaxCount;
    count_d    = over ? MaxCount[CountW-1:0] : sum[CountW-1:0];
    overflow_d = overflow_q | over;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q    <= MaxCount[CountW-1:0];
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/bsg_link_credit_serializer.sv
// Splits core words into link-width pieces, sent LSB first, gated by receiver credits.
module bsg_link_credit_serializer
  import bsg_link_pkg::*;
#(
  parameter int unsigned width_p               = 64,
  parameter int unsigned channel_width_p       = 16,
  parameter int unsigned num_channels_p        = 2,
  parameter int unsigned lg_credits_p          = 3,
  parameter int unsigned lg_token_decimation_p = 1
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [width_p-1:0]                        data_i,
  input  logic                                      v_i,
  output logic                                      ready_o,
  output logic [channel_width_p*num_channels_p-1:0] link_data_o,
  output logic                                      link_v_o,
  input  logic                                      token_i,
  output logic [lg_credits_p:0]                     credits_o,
  output logic                                      overflow_o
);

  localparam int unsigned LinkW     = channel_width_p * num_channels_p;
  localparam int unsigned NumPieces = ceil_div(width_p, LinkW);
  localparam int unsigned IdxW      = (NumPieces > 1) ? $clog2(NumPieces) : 1;
  localparam int unsigned HoldW     = NumPieces * LinkW;
  localparam int unsigned CreditW   = lg_credits_p + 1;
  localparam logic [IdxW-1:0]    LastIdx  = IdxW'(NumPieces - 1);
  localparam logic [CreditW-1:0] TokenInc = CreditW'(1) << lg_token_decimation_p;

  link_state_e state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [HoldW-1:0] hold_q, hold_d;

  logic [NumPieces-1:0][LinkW-1:0] pieces;
  logic credit_avail, sending, last_piece, accept;

  assign credit_avail = |credits_o;
  assign sending      = state_q == StSend;
  assign last_piece   = idx_q == LastIdx;

  // Ready is also offered on the last piece so consecutive words leave no bubble.
  assign ready_o  = ~reset_i & (~sending | (last_piece & credit_avail));
  assign link_v_o = sending & credit_avail;
  assign accept   = v_i & ready_o;

  // Zero-extended hold register makes the top bits of a short last piece zero.
  assign pieces      = hold_q;
  assign link_data_o = pieces[idx_q];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    if (accept) begin
      hold_d = HoldW'(data_i);
    end
    if (link_v_o) begin
      idx_d = last_piece ? '0 : idx_q + IdxW'(1);
    end
    unique case (state_q)
      StIdle: if (accept) state_d = StSend;
      StSend: if (link_v_o && last_piece && !accept) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  bsg_link_credit_counter #(
    .lg_max_p (lg_credits_p)
  ) u_credit_counter (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .inc_i      (token_i ? TokenInc : '0),
    .dec_i      (link_v_o),
    .count_o    (credits_o),
    .overflow_o (overflow_o)
  );

endmodule

// File: doc/bsg_link_credit_serializer.md
BSG_LINK_CREDIT_SERIALIZER -- requirements
Module: bsg_link_credit_serializer

Interface
REQ-001 SHALL have parameter width_p, default 64: core word width in bits.
REQ-002 SHALL have parameter channel_width_p, default 16: bits per physical channel.
REQ-003 SHALL have parameter num_channels_p, default 2, legal 1..8: number of parallel channels.
REQ-004 SHALL have parameter lg_credits_p, default 3: receiver buffer depth 2^lg_credits_p pieces, which is also the initial credit count.
REQ-005 SHALL have parameter lg_token_decimation_p, default 1: each token pulse returns 2^lg_token_decimation_p credits.
REQ-006 SHALL have port clk_i, input, 1 bit: sole clock; all logic is on the rising edge.
REQ-007 SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port data_i, input, width_p bits: core word.
REQ-009 SHALL have port v_i, input, 1 bit: data_i valid.
REQ-010 SHALL have port ready_o, output, 1 bit: block accepts data_i this cycle.
REQ-011 SHALL have port link_data_o, output, channel_width_p*num_channels_p bits: current piece.
REQ-012 SHALL have port link_v_o, output, 1 bit: link_data_o valid; one credit is consumed per high cycle.
REQ-013 SHALL have port token_i, input, 1 bit: single-cycle credit-return pulse, synchronous to clk_i.
REQ-014 SHALL have port credits_o, output, lg_credits_p+1 bits: current credit count.
REQ-015 SHALL have port overflow_o, output, 1 bit: sticky credit-overflow error flag.

Function
REQ-016 SHALL define P = link width (channel_width_p*num_channels_p) and N = ceil(width_p/P) pieces per word.
REQ-017 SHALL accept a word on a cycle where v_i and ready_o are both high, capturing it into a hold register.
REQ-018 SHALL implement FSM IDLE/SEND: IDLE->SEND on accept; SEND->IDLE after piece N-1 is sent with no new accept; SEND->SEND on the last piece when a new word is accepted in the same cycle.
REQ-019 SHALL drive ready_o = IDLE, OR (SEND and piece index = N-1 and credits_o > 0), giving back-to-back words with no bubble.
REQ-020 SHALL drive link_v_o = SEND and credits_o > 0; the first piece appears in the cycle after acceptance.
REQ-021 SHALL send pieces least-significant first: piece k = hold[k*P +: P]; the upper bits of the last piece are zero when width_p is not a multiple of P.
REQ-022 SHALL advance the piece index only on cycles where link_v_o is high, wrapping to 0 after N-1.
REQ-023 SHALL hold link_data_o and the piece index stable while credits_o = 0 (stall).
REQ-024 SHALL update credits each cycle as credits + (token_i ? 2^lg_token_decimation_p : 0) - link_v_o; a simultaneous token and send SHALL net in the same cycle.
REQ-025 SHALL, when an update would exceed 2^lg_credits_p, saturate credits at 2^lg_credits_p and set overflow_o; overflow_o SHALL hold until reset.
REQ-026 SHALL never let credits go below 0; this follows structurally from REQ-020.
REQ-027 SHALL treat v_i as don't-care while ready_o is low; data_i is sampled only on accept.

Reset
REQ-028 SHALL, on reset_i assertion (asynchronous), force state IDLE, piece index 0, hold register 0, credits_o = 2^lg_credits_p, overflow_o 0, link_v_o 0 and ready_o 0.
REQ-029 SHALL raise ready_o in the first cycle after reset_i deasserts.
REQ-030 SHALL discard any partially sent word when reset is asserted mid-word; there is no resumption.

Structure
REQ-031 SHALL place the FSM state enum and a ceil-divide piece-count function in shared package bsg_link_pkg.
REQ-032 SHALL place the saturating credit up/down counter in sub-module bsg_link_credit_counter, with ports for inc amount, dec, count and overflow.
REQ-033 SHALL contain no clock-domain crossing; token_i is synchronised externally.

Verification (width_p=64, channel_width_p=16, num_channels_p=2, lg_credits_p=3, lg_token_decimation_p=1; so P=32, N=2)
REQ-034 SHALL cover: reset pulse -> link_v_o=0, overflow_o=0, credits_o=8; ready_o=1 in the cycle after deassert.
REQ-035 SHALL cover: accept 0x1111_2222_3333_4444 -> link_data_o=0x3333_4444 then 0x1111_2222 on consecutive cycles; credits_o 8->7->6.
REQ-036 SHALL cover: 5 words offered with no tokens -> 8 pieces sent, then link_v_o=0 with link_data_o held; one token_i pulse -> exactly 2 more pieces, credits_o returns to 0.
REQ-037 SHALL cover: credits_o=1 with token_i and link_v_o in the same cycle -> credits_o=2 in the next cycle.
REQ-038 SHALL cover: token_i at credits_o=8 -> credits_o stays 8, overflow_o=1 and remains 1 until reset.
REQ-039 SHALL cover: reset asserted after piece 0 of a word -> piece 1 is never sent; credits_o=8 after reset.
